// File: rtl/cla_addsub_pipe_if.sv
// Operand/result handshake bundle for cla_addsub_pipe.
// The sat signal exists only when CLA_ADDSUB_SAT_EN is defined.
interface cla_addsub_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
`ifdef CLA_ADDSUB_SAT_EN
    logic             sat;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

`ifdef CLA_ADDSUB_SAT_EN
    modport master (
        output in_valid, a, b, sub, sat, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );
    modport slave (
        input  in_valid, a, b, sub, sat, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
`else
    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );
    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
`endif
endinterface

// File: rtl/cla_addsub_pipe.sv
// Two-stage carry-lookahead adder/subtractor: stage 1 forms bit and group P/G,
// stage 2 resolves carries and flags. Define CLA_ADDSUB_SAT_EN for saturation.
module cla_addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    cla_addsub_pipe_if.slave bus
);
    localparam int NG = WIDTH / GROUP;

    logic             s1_en;
    logic             s2_en;
    logic             s1_load;
    logic             s2_load;

    logic             s1_valid_q,  s1_valid_d;
    logic [WIDTH-1:0] s1_p_q,      s1_p_d;
    logic [WIDTH-1:0] s1_g_q,      s1_g_d;
    logic [NG-1:0]    s1_gp_q,     s1_gp_d;
    logic [NG-1:0]    s1_gg_q,     s1_gg_d;
    logic             s1_a_msb_q,  s1_a_msb_d;
    logic             s1_bb_msb_q, s1_bb_msb_d;
    logic             s1_cin_q,    s1_cin_d;
`ifdef CLA_ADDSUB_SAT_EN
    logic             s1_sat_q,    s1_sat_d;
`endif

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q,       sum_d;
    logic             cout_q,      cout_d;
    logic             ovf_q,       ovf_d;
    logic             zero_q,      zero_d;

    logic [WIDTH-1:0] bb;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] g_in;
    logic [NG-1:0]    gp_in;
    logic [NG-1:0]    gg_in;
    logic [NG:0]      grp_c;
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_raw;
    logic             ovf_raw;

    // S2 drains when empty or accepted downstream; S1 refills whenever S2 can take it.
    assign s2_en        = ~out_valid_q | bus.out_ready;
    assign s1_en        = ~s1_valid_q | s2_en;
    assign s1_load      = bus.in_valid & s1_en;
    assign s2_load      = s1_valid_q & s2_en;
    assign bus.in_ready = s1_en;

    always_comb begin
        bb    = bus.b ^ {WIDTH{bus.sub}};
        p_in  = bus.a ^ bb;
        g_in  = bus.a & bb;
        gp_in = '0;
        gg_in = '0;
        for (int k = 0; k < NG; k++) begin
            gp_in[k] = &p_in[k*GROUP +: GROUP];
            for (int j = 0; j < GROUP; j++) begin
                gg_in[k] = g_in[k*GROUP+j] | (p_in[k*GROUP+j] & gg_in[k]);
            end
        end
    end

    always_comb begin
        s1_valid_d  = s1_en ? bus.in_valid : s1_valid_q;
        s1_p_d      = s1_p_q;
        s1_g_d      = s1_g_q;
        s1_gp_d     = s1_gp_q;
        s1_gg_d     = s1_gg_q;
        s1_a_msb_d  = s1_a_msb_q;
        s1_bb_msb_d = s1_bb_msb_q;
        s1_cin_d    = s1_cin_q;
`ifdef CLA_ADDSUB_SAT_EN
        s1_sat_d    = s1_sat_q;
`endif
        if (s1_load) begin
            s1_p_d      = p_in;
            s1_g_d      = g_in;
            s1_gp_d     = gp_in;
            s1_gg_d     = gg_in;
            s1_a_msb_d  = bus.a[WIDTH-1];
            s1_bb_msb_d = bb[WIDTH-1];
            s1_cin_d    = bus.sub;
`ifdef CLA_ADDSUB_SAT_EN
            s1_sat_d    = bus.sat;
`endif
        end
    end

    // Stage 1 boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_p_q      <= '0;
            s1_g_q      <= '0;
            s1_gp_q     <= '0;
            s1_gg_q     <= '0;
            s1_a_msb_q  <= 1'b0;
            s1_bb_msb_q <= 1'b0;
            s1_cin_q    <= 1'b0;
`ifdef CLA_ADDSUB_SAT_EN
            s1_sat_q    <= 1'b0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_p_q      <= s1_p_d;
            s1_g_q      <= s1_g_d;
            s1_gp_q     <= s1_gp_d;
            s1_gg_q     <= s1_gg_d;
            s1_a_msb_q  <= s1_a_msb_d;
            s1_bb_msb_q <= s1_bb_msb_d;
            s1_cin_q    <= s1_cin_d;
`ifdef CLA_ADDSUB_SAT_EN
            s1_sat_q    <= s1_sat_d;
`endif
        end
    end

    // Group carries look ahead across groups; inside a group carries ripple from the group carry-in.
    always_comb begin
        grp_c    = '0;
        c        = '0;
        grp_c[0] = s1_cin_q;
        for (int k = 0; k < NG; k++) begin
            grp_c[k+1] = s1_gg_q[k] | (s1_gp_q[k] & grp_c[k]);
        end
        for (int k = 0; k < NG; k++) begin
            c[k*GROUP] = grp_c[k];
            for (int j = 1; j < GROUP; j++) begin
                c[k*GROUP+j] = s1_g_q[k*GROUP+j-1] | (s1_p_q[k*GROUP+j-1] & c[k*GROUP+j-1]);
            end
        end
        c[WIDTH] = grp_c[NG];
        sum_raw  = s1_p_q ^ c[WIDTH-1:0];
        ovf_raw  = (s1_a_msb_q == s1_bb_msb_q) & (sum_raw[WIDTH-1] != s1_a_msb_q);
    end

    always_comb begin
        out_valid_d = s2_en ? s1_valid_q : out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        if (s2_load) begin
            sum_d = sum_raw;
`ifdef CLA_ADDSUB_SAT_EN
            if (s1_sat_q && ovf_raw) begin
                sum_d = s1_a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end
`endif
            cout_d = c[WIDTH];
            ovf_d  = ovf_raw;
            zero_d = ~|sum_d;
        end
    end

    // Stage 2 boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Bench for cla_addsub_pipe: directed boundaries plus randomized streams on a
// 16/4 and a 32/8 instance, scored against an integer-arithmetic model.
module tb_cla_addsub_pipe;
    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

`ifdef CLA_ADDSUB_SAT_EN
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst16_n;
    logic rst32_n;
    logic sat16;
    logic sat32;
    int   n_checks = 0;
    int   n_fail   = 0;
    res_t q16[$];
    res_t q32[$];
    int   got16;
    logic acc16;
    logic acc32;
    logic rdy16;
    logic done32 = 1'b0;

    cla_addsub_pipe_if #(.WIDTH(16)) bus16 ();
    cla_addsub_pipe_if #(.WIDTH(32)) bus32 ();
`ifdef CLA_ADDSUB_SAT_EN
    assign bus16.sat = sat16;
    assign bus32.sat = sat32;
`endif

    cla_addsub_pipe #(.WIDTH(16), .GROUP(4)) dut16 (.clk(clk), .rst_n(rst16_n), .bus(bus16.slave));
    cla_addsub_pipe #(.WIDTH(32), .GROUP(8)) dut32 (.clk(clk), .rst_n(rst32_n), .bus(bus32.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic res_t ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                       input logic s, input logic sat);
        res_t   r;
        longint full, half, ua, ub, us, sa, sb, sres;
        full = longint'(1) <<< w;
        half = full / 2;
        ua   = longint'(a);
        ub   = longint'(b);
        us   = s ? ua + (full - 1 - ub) + 1 : ua + ub;
        sa   = (ua >= half) ? ua - full : ua;
        sb   = (ub >= half) ? ub - full : ub;
        sres = s ? sa - sb : sa + sb;
        r.ovf  = (sres >= half) || (sres < -half);
        r.cout = (us >= full);
        r.sum  = 64'(us % full);
        if (sat && r.ovf) r.sum = (sres > 0) ? 64'(half - 1) : 64'(half);
        r.zero = (r.sum == 64'd0);
        return r;
    endfunction

    function automatic logic [63:0] rnd_op(input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 9))
            0:       return 64'd0;
            1:       return mask;
            2:       return mask >> 1;
            3:       return (mask >> 1) + 64'd1;
            4:       return 64'd1;
            default: return {32'd0, $urandom} & mask;
        endcase
    endfunction

    task automatic step16();
        res_t e;
        #1;
        rdy16 = bus16.in_ready;
        if (bus16.out_valid && bus16.out_ready) begin
            got16++;
            if (q16.size() == 0) begin
                check("spurious_out16", 64'(bus16.out_valid), 64'd0);
            end else begin
                e = q16.pop_front();
                check("sb16_sum",  64'(bus16.sum),  e.sum);
                check("sb16_cout", 64'(bus16.cout), 64'(e.cout));
                check("sb16_ovf",  64'(bus16.ovf),  64'(e.ovf));
                check("sb16_zero", 64'(bus16.zero), 64'(e.zero));
            end
        end
        acc16 = bus16.in_valid && bus16.in_ready;
        if (acc16) q16.push_back(ref_model(16, 64'(bus16.a), 64'(bus16.b), bus16.sub, sat16 & SAT_ON));
        @(negedge clk);
    endtask

    task automatic step32();
        res_t e;
        #1;
        if (bus32.out_valid && bus32.out_ready) begin
            if (q32.size() == 0) begin
                check("spurious_out32", 64'(bus32.out_valid), 64'd0);
            end else begin
                e = q32.pop_front();
                check("sb32_sum",  64'(bus32.sum),  e.sum);
                check("sb32_cout", 64'(bus32.cout), 64'(e.cout));
                check("sb32_ovf",  64'(bus32.ovf),  64'(e.ovf));
                check("sb32_zero", 64'(bus32.zero), 64'(e.zero));
            end
        end
        acc32 = bus32.in_valid && bus32.in_ready;
        if (acc32) q32.push_back(ref_model(32, 64'(bus32.a), 64'(bus32.b), bus32.sub, sat32 & SAT_ON));
        @(negedge clk);
    endtask

    // Single transaction into an empty pipe; result must appear exactly two edges later.
    task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic s, input logic sat, input logic [15:0] es,
                            input logic ec, input logic eo, input logic ez);
        bus16.a = a; bus16.b = b; bus16.sub = s; sat16 = sat;
        bus16.in_valid = 1'b1; bus16.out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, 64'(bus16.in_ready), 64'd1);
        @(negedge clk);
        bus16.in_valid = 1'b0;
        #1 check({tag, "_early_valid"}, 64'(bus16.out_valid), 64'd0);
        @(negedge clk);
        #1;
        check({tag, "_valid"}, 64'(bus16.out_valid), 64'd1);
        check({tag, "_sum"},   64'(bus16.sum),  64'(es));
        check({tag, "_cout"},  64'(bus16.cout), 64'(ec));
        check({tag, "_ovf"},   64'(bus16.ovf),  64'(eo));
        check({tag, "_zero"},  64'(bus16.zero), 64'(ez));
        @(negedge clk);
    endtask

    initial begin
        int   sent;
        logic stall;
        rst16_n = 1'b0;
        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.sub = 1'b0; bus16.out_ready = 1'b0;
        sat16 = 1'b0; acc16 = 1'b0; got16 = 0; rdy16 = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", 64'(bus16.out_valid), 64'd0);
        check("reset_sum",       64'(bus16.sum),       64'd0);
        check("reset_in_ready",  64'(bus16.in_ready),  64'd1);
        check("reset_flags",     {61'd0, bus16.cout, bus16.ovf, bus16.zero}, 64'd0);
        rst16_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1 check("idle_out_valid", 64'(bus16.out_valid), 64'd0);
        end
        @(negedge clk);

        directed("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        directed("sub_neg",   16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        directed("pos_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        directed("wrap",      16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        directed("neg_ovf",   16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        directed("a_minus_a", 16'h3C3C, 16'h3C3C, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
`ifdef CLA_ADDSUB_SAT_EN
        directed("sat_pos",   16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        directed("sat_neg",   16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
`endif

        // Back-to-back stream with a backpressure window.
        sent = 0; stall = 1'b0; got16 = 0; acc16 = 1'b0; sat16 = 1'b0;
        for (int cyc = 0; cyc < 60 && (sent < 8 || q16.size() > 0); cyc++) begin
            if (sent < 8) begin
                if (!(bus16.in_valid && !acc16)) begin
                    bus16.a = 16'($urandom); bus16.b = 16'($urandom); bus16.sub = 1'($urandom);
                end
                bus16.in_valid = 1'b1;
            end else begin
                bus16.in_valid = 1'b0;
            end
            bus16.out_ready = !(cyc >= 3 && cyc <= 6);
            step16();
            if (acc16) sent++;
            if (!rdy16) stall = 1'b1;
        end
        check("bp_stall_seen", 64'(stall), 64'd1);
        check("bp_sent",       64'(sent),  64'd8);
        check("bp_received",   64'(got16), 64'd8);
        check("bp_drained",    64'(q16.size()), 64'd0);

        // Fill both stages, then reset mid-stream.
        bus16.out_ready = 1'b0; bus16.in_valid = 1'b0; acc16 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (!(bus16.in_valid && !acc16)) begin
                bus16.a = 16'($urandom); bus16.b = 16'($urandom); bus16.sub = 1'($urandom);
            end
            bus16.in_valid = 1'b1;
            step16();
        end
        #1;
        check("full_out_valid", 64'(bus16.out_valid), 64'd1);
        check("full_in_ready",  64'(bus16.in_ready),  64'd0);
        rst16_n = 1'b0; bus16.in_valid = 1'b0;
        #1;
        check("rst_mid_out_valid", 64'(bus16.out_valid), 64'd0);
        check("rst_mid_sum",       64'(bus16.sum),       64'd0);
        q16.delete(); acc16 = 1'b0;
        repeat (2) @(negedge clk);
        rst16_n = 1'b1; bus16.out_ready = 1'b1; got16 = 0;
        for (int i = 0; i < 4; i++) step16();
        check("post_rst_quiet", 64'(got16), 64'd0);
        bus16.a = 16'h0F0F; bus16.b = 16'h1111; bus16.sub = 1'b1; bus16.in_valid = 1'b1;
        for (int i = 0; i < 10 && !acc16; i++) step16();
        bus16.in_valid = 1'b0;
        for (int i = 0; i < 10 && q16.size() > 0; i++) step16();
        check("post_rst_first", 64'(got16), 64'd1);

        // Random regression, 16/4.
        acc16 = 1'b0; bus16.in_valid = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (!(bus16.in_valid && !acc16)) begin
                bus16.in_valid = ($urandom_range(0, 3) != 0);
                bus16.a = 16'(rnd_op(16)); bus16.b = 16'(rnd_op(16));
                bus16.sub = 1'($urandom); sat16 = 1'($urandom);
            end
            bus16.out_ready = ($urandom_range(0, 3) != 0);
            step16();
        end
        bus16.in_valid = 1'b0; bus16.out_ready = 1'b1;
        for (int i = 0; i < 20 && q16.size() > 0; i++) step16();
        check("drain16", 64'(q16.size()), 64'd0);

        for (int i = 0; i < 500 && !done32; i++) @(negedge clk);
        check("done32", 64'(done32), 64'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Random regression, 32/8, in parallel on its own reset.
    initial begin
        rst32_n = 1'b0;
        bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.sub = 1'b0; bus32.out_ready = 1'b0;
        sat32 = 1'b0; acc32 = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset32_out_valid", 64'(bus32.out_valid), 64'd0);
        check("reset32_sum",       64'(bus32.sum),       64'd0);
        rst32_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10000; i++) begin
            if (!(bus32.in_valid && !acc32)) begin
                bus32.in_valid = ($urandom_range(0, 3) != 0);
                bus32.a = 32'(rnd_op(32)); bus32.b = 32'(rnd_op(32));
                bus32.sub = 1'($urandom); sat32 = 1'($urandom);
            end
            bus32.out_ready = ($urandom_range(0, 3) != 0);
            step32();
        end
        bus32.in_valid = 1'b0; bus32.out_ready = 1'b1;
        for (int i = 0; i < 20 && q32.size() > 0; i++) step32();
        check("drain32", 64'(q32.size()), 64'd0);
        done32 = 1'b1;
    end
endmodule

// File: doc/cla_addsub_pipe.md
Name: cla_addsub_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the calculator datapath.
- Generalises the per-bit propagate/generate cell to WIDTH bits, with group lookahead of size GROUP.
- Two-stage pipeline with valid/ready handshakes on both sides.
- Sits between operand registers and the result/display formatter.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of GROUP, range 4..64
GROUP, 4, lookahead group size in bits; per-group P/G are computed in stage 1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a, b, sub are valid this cycle
in_ready  output  1  block accepts operands this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sub  input  1  0: a+b; 1: a-b, computed as a + ~b + 1
out_valid  output  1  result fields are valid
out_ready  input  1  downstream accepts the result
sum  output  WIDTH  result, modulo 2^WIDTH
cout  output  1  carry out of the MSB; for sub, 1 means no borrow (a >= b unsigned)
ovf  output  1  two's-complement signed overflow
zero  output  1  sum == 0

Behaviour:
- Reset: when rst_n is low, all registers clear immediately (asynchronous). out_valid=0, sum=0, cout=0, ovf=0, zero=0. Internal stage-1 valid=0. in_ready=1 while in reset and after it.
- Stage 1 (S1), registered on an in_valid & in_ready handshake:
  - bb = b ^ {WIDTH{sub}}; cin = sub
  - per bit: p[i] = a[i]^bb[i], g[i] = a[i]&bb[i]
  - per group k: P_k = AND of the group's p bits; G_k = the group's generate
  - S1 also holds a[MSB], bb[MSB] and cin
- Stage 2 (S2), registered when S1 is valid and S2 can advance:
  - group carries: c_{k+1} = G_k | P_k&c_k, with c_0 = cin
  - in-group carries: ripple lookahead from c_k
  - sum[i] = p[i]^c[i]; cout = c[WIDTH]
  - ovf = (a[MSB]==bb[MSB]) & (sum[MSB]!=a[MSB]); zero = ~|sum
- Latency: 2 cycles from the accepting in_valid&in_ready edge to out_valid=1. Throughput is 1 result per cycle when out_ready=1.
- Flow control:
  - S2 advance enable: s2_en = ~out_valid | out_ready
  - s1_en = ~s1_valid | s2_en; in_ready = s1_en (combinational from out_ready and the valid registers)
  - Outputs hold stable while out_valid=1 and out_ready=0. No result is dropped or duplicated.
- Simultaneous events:
  - A new input accepted in the same cycle that S1 drains into S2: both occur, S1 is replaced.
  - out_ready=1 with S1 empty: out_valid drops to 0 next cycle.
- Reset mid-operation: all in-flight results are discarded; no out_valid pulse after reset deasserts.
- Boundaries, shown for WIDTH=16:
  - 0xFFFF+0x0001 -> sum=0, cout=1, zero=1, ovf=0
  - 0x7FFF+1 -> ovf=1
  - 0x8000-1 -> ovf=1
  - a-a -> zero=1, cout=1
- in_valid while in_ready=0 is ignored. The source holds a, b and sub stable until the handshake completes.

Optional Feature:
Macro CLA_ADDSUB_SAT_EN.
- Defined:
  - adds input port sat (1 bit), captured with the operands
  - when sat=1 and ovf=1, sum clamps to 0x7FF..F on positive overflow (a[MSB]=0) or 0x800..0 on negative overflow
  - ovf still reports 1; zero is computed on the clamped value
- Undefined: port sat is absent and sum always wraps modulo 2^WIDTH.

Test Plan:
1. Reset then idle: rst_n low for 3 cycles, release -> out_valid=0, sum=0, in_ready=1; no out_valid over 10 idle cycles.
2. Add/sub basics, WIDTH=16, out_ready=1:
   - 0x1234+0x4321 -> 0x5555, cout=0, ovf=0, two cycles after the handshake
   - 0x0005-0x0007 -> 0xFFFE, cout=0
3. Overflow and wrap:
   - 0x7FFF+0x0001 -> 0x8000, ovf=1
   - 0xFFFF+0x0001 -> 0x0000, cout=1, zero=1
   - with CLA_ADDSUB_SAT_EN and sat=1, 0x7FFF+0x0001 -> 0x7FFF, ovf=1
4. Back-to-back with backpressure:
   - stream 8 random operand pairs with in_valid=1, holding out_ready=0 for cycles 3-6
   - required: in_ready falls after S1 and S2 fill, results arrive in order matching the reference model, no loss or duplication
5. Reset mid-stream: assert rst_n low while S1 and S2 are both valid -> out_valid=0 immediately; after release, the first result seen is the first new input.
6. Random regression:
   - 10k random a, b, sub, out_ready patterns for WIDTH=16/GROUP=4 and WIDTH=32/GROUP=8
   - compare sum, cout, ovf and zero against a behavioural model
